window3x3_linebuf: RTL and testbench
====================================

Name: window3x3_linebuf

Overview:
- Streaming 3x3 sliding-window generator, stride 1, sitting directly upstream of minpool.
- Accepts a raster-order pixel stream of an IMG_H x IMG_W feature map (default 8x8).
- Emits one 3x3 window per valid output position: (IMG_H-2)*(IMG_W-2) = 36 windows per default frame, in raster order.
- Uses two row line buffers plus a 3x3 register array; valid/ready handshake on both sides.

Parameters:
DATA_WIDTH, 8, pixel width in bits.
IMG_W, 8, pixels per row; legal range 3..256.
IMG_H, 8, rows per frame; legal range 3..256.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  reset; synchronous, active-high.
in_valid  in  1  pixel present on in_data.
in_ready  out  1  block can accept a pixel this cycle.
in_data  in  DATA_WIDTH  pixel value, raster order: row 0 col 0 first.
win_valid  out  1  win_data holds a complete window.
win_ready  in  1  consumer accepts the window this cycle.
win_data  out  9*DATA_WIDTH  window; element (r,c) at bits [(3r+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest row, c=0 the leftmost column; element (2,2) is the newest pixel.
win_row  out  8  top-left row index of the window, 0..IMG_H-3.
win_col  out  8  top-left column index of the window, 0..IMG_W-3.
win_last  out  1  high with win_valid on the final window of a frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - col/row counters go to 0.
  - win_valid, win_data, win_row, win_col and win_last go to 0.
  - Line buffer contents are unspecified and must never be observable.
- Reset mid-frame aborts the frame; the next accepted pixel is (0,0).
- Pixel acceptance: accept = in_valid && in_ready, with in_ready = !win_valid || win_ready (combinational). in_ready is 1 out of reset.
- On each accept of pixel p at position (row,col):
  - The new column is {lb1[col], lb0[col], p}, where lb1 holds row-2 and lb0 holds row-1.
  - lb1[col] <= lb0[col]; lb0[col] <= p.
  - The 3x3 array shifts left one column and the new column enters at c=2.
  - Counters advance: col wraps at IMG_W-1 to 0 and increments row; row wraps at IMG_H-1 to 0, so the next frame follows back-to-back.
- Window emission:
  - Emit only if row>=2 and col>=2 for the accepted pixel.
  - On the next edge: win_valid <= 1, win_data <= updated array, win_row = row-2, win_col = col-2, win_last = (row==IMG_H-1 && col==IMG_W-1).
  - Latency is 1 cycle from accept to win_valid.
- Output hold: while win_valid && !win_ready, all win_* outputs are stable and in_ready=0, so no pixel is lost.
- Window clear: win_valid drops on win_ready unless a new window is loaded in the same cycle (simultaneous drain and load gives the new window).
- Throughput: with in_valid=1 and win_ready=1, one pixel and, in the window region, one window per cycle, with no bubbles.
- Stale columns: at col 0/1 the array holds columns from the previous row; these are never emitted.
- Data passes unmodified; no arithmetic on pixel values.

Decomposition:
- Package minpool_pkg holds:
  - DATA_WIDTH default and KERNEL=3.
  - A function win_idx(r,c) = 3r+c.
  - Localparam POOL_W/POOL_H = IMG-KERNEL+1, shared with minpool.
- One sub-module, row_linebuf: IMG_W x DATA_WIDTH storage with a registered write and a combinational read at the same address (read-old-data). It is instantiated twice, as lb0 and lb1.

Test Plan:
1. Ramp frame (pixel = 8r+c), win_ready=1 throughout -> 36 windows.
   - First window {0,1,2,8,9,10,16,17,18}, row=0, col=0, appears 1 cycle after pixel 18 is accepted.
   - Last window {45,46,47,53,54,55,61,62,63}, row=5, col=5, win_last=1.
2. Backpressure: win_ready=0 for 5 cycles during the window at (2,3) -> win_data stays {19,20,21,27,28,29,35,36,37}, in_ready=0, and the full window sequence matches scenario 1.
3. Random in_valid gaps (50% duty) -> window values and order identical to scenario 1; no extra or missing windows.
4. Two back-to-back frames, second frame = ramp+64 -> frame 2 first window {64,65,66,72,73,74,80,81,82}; 72 windows in total; win_last on windows 36 and 72 only.
5. rst=1 for 1 cycle after 20 pixels accepted -> next cycle win_valid=0 and in_ready=1; a fresh ramp frame reproduces scenario 1 exactly.
6. Steady state in_valid=win_ready=1 -> row 4 yields windows on 6 consecutive cycles, with win_col 0..5 in order.

Source files
------------

// File: rtl/minpool_pkg.sv
// Shared constants and helpers for the 3x3 window generator and minpool.
package minpool_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_IMG_W      = 8;
  localparam int unsigned DEF_IMG_H      = 8;
  localparam int unsigned KERNEL         = 3;

  // Output grid of a stride-1 KERNELxKERNEL window over the default frame.
  localparam int unsigned POOL_W = DEF_IMG_W - KERNEL + 1;
  localparam int unsigned POOL_H = DEF_IMG_H - KERNEL + 1;

  // Flat element index of window element (r,c); r=0 is the oldest row.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return KERNEL * r + c;
  endfunction

endpackage

// File: rtl/window3x3_linebuf_row_linebuf.sv
// One image row of pixel storage: registered write, combinational read-old-data.
module row_linebuf #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Read returns the value stored before any write at this edge.
  assign rdata_o = mem_q[addr_i];

  // Write the new value at the current column.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/window3x3_linebuf.sv
// Streaming 3x3 stride-1 window generator built from two line buffers and a 3x3 register array.
module window3x3_linebuf
  import minpool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [9*DATA_WIDTH-1:0] win_data,
  output logic [7:0]              win_row,
  output logic [7:0]              win_col,
  output logic                    win_last
);

  localparam int unsigned AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned NELEM = KERNEL * KERNEL;

  logic [7:0]              col_q, col_d, row_q, row_d;
  logic [DATA_WIDTH-1:0]   arr_q [NELEM];
  logic [DATA_WIDTH-1:0]   arr_d [NELEM];
  logic                    win_valid_q, win_valid_d;
  logic [9*DATA_WIDTH-1:0] win_data_q, win_data_d;
  logic [7:0]              win_row_q, win_row_d, win_col_q, win_col_d;
  logic                    win_last_q, win_last_d;
  logic                    accept;
  logic [AW-1:0]           lb_addr;
  logic [DATA_WIDTH-1:0]   lb0_rd, lb1_rd;

  // Stall the input only while a window is held against backpressure.
  assign in_ready = !win_valid_q || win_ready;
  assign accept   = in_valid && in_ready;
  assign lb_addr  = AW'(col_q);

  // lb0 holds row-1, lb1 holds row-2; lb1 is fed from lb0's old data.
  row_linebuf #(.DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH)) lb0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (lb_addr),
    .wdata_i (in_data),
    .rdata_o (lb0_rd)
  );

  row_linebuf #(.DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH)) lb1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (lb_addr),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Shift the window, advance raster counters and load an output window when complete.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    arr_d       = arr_q;
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_last_d  = win_last_q;

    if (win_ready) begin
      win_valid_d = 1'b0;
    end

    if (accept) begin
      arr_d[win_idx(0, 0)] = arr_q[win_idx(0, 1)];
      arr_d[win_idx(0, 1)] = arr_q[win_idx(0, 2)];
      arr_d[win_idx(1, 0)] = arr_q[win_idx(1, 1)];
      arr_d[win_idx(1, 1)] = arr_q[win_idx(1, 2)];
      arr_d[win_idx(2, 0)] = arr_q[win_idx(2, 1)];
      arr_d[win_idx(2, 1)] = arr_q[win_idx(2, 2)];
      arr_d[win_idx(0, 2)] = lb1_rd;
      arr_d[win_idx(1, 2)] = lb0_rd;
      arr_d[win_idx(2, 2)] = in_data;

      if (col_q == 8'(IMG_W - 1)) begin
        col_d = 8'd0;
        row_d = (row_q == 8'(IMG_H - 1)) ? 8'd0 : row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end

      // Columns 0/1 still hold the previous row's tail, so only col>=2 is a real window.
      if (row_q >= 8'd2 && col_q >= 8'd2) begin
        win_valid_d = 1'b1;
        win_data_d  = {arr_d[8], arr_d[7], arr_d[6], arr_d[5], arr_d[4],
                       arr_d[3], arr_d[2], arr_d[1], arr_d[0]};
        win_row_d   = row_q - 8'd2;
        win_col_d   = col_q - 8'd2;
        win_last_d  = (row_q == 8'(IMG_H - 1)) && (col_q == 8'(IMG_W - 1));
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= 8'd0;
      row_q       <= 8'd0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_row_q   <= 8'd0;
      win_col_q   <= 8'd0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_last_q  <= win_last_d;
    end
  end

  // Window shift array; stale contents are never emitted so no reset is needed.
  always_ff @(posedge clk) begin
    arr_q <= arr_d;
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_last  = win_last_q;

endmodule

// File: tb/tb_window3x3_linebuf.sv
// Randomized scoreboard bench for window3x3_linebuf against a frame-array reference model.
module tb_window3x3_linebuf;

  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, win_valid, win_ready, win_last;
  logic [7:0]  in_data, win_row, win_col;
  logic [71:0] win_data;

  always #5 clk = ~clk;

  window3x3_linebuf dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last)
  );

  typedef struct {
    logic [71:0] data;
    int          row;
    int          col;
    bit          last;
    int          acc;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         mr = 0, mc = 0;
  logic [7:0] img [H][W];
  int         wins_seen = 0, lasts_seen = 0;
  int         hs_cyc [H][W];
  bit         gaps = 0;
  int         wr_mode = 0;
  int         bp_cnt = 0;

  // monitor history
  bit          pv = 0, phs = 0, phold = 0;
  logic [71:0] pd;
  logic [7:0]  pr, pc;
  logic        pl;
  int          pres = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: store the frame as a 2D image; every pixel at row>=2,col>=2 completes the
  // 3x3 neighbourhood whose bottom-right corner it is.
  task automatic model_accept(input logic [7:0] p);
    exp_t e;
    img[mr][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      e.data = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.data[(3*i+j)*8 +: 8] = img[mr-2+i][mc-2+j];
      e.row  = mr - 2;
      e.col  = mc - 2;
      e.last = (mr == H-1) && (mc == W-1);
      e.acc  = cyc;
      expq.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end
  endtask

  task automatic drive_pixel(input logic [7:0] p);
    int tries = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = p;
        #1;
        if (in_ready) begin
          model_accept(p);
          done = 1;
        end
      end
      tries++;
      if (!done && tries > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout pixel=%0d actual=no_accept required=accept", p);
        done = 1;
      end
    end
  endtask

  task automatic run_frame(input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        drive_pixel(8'(base + 8*r + c));
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", expq.size());
      expq.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Consumer-side ready generation.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (wr_mode)
        1: win_ready = 1'($urandom_range(0, 1));
        2: begin
          if (win_valid && win_row == 8'd2 && win_col == 8'd3 && bp_cnt < 5) begin
            win_ready = 1'b0;
            bp_cnt++;
          end else begin
            win_ready = 1'b1;
          end
        end
        default: win_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each window handshake; checks hold stability and latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pv = 0; phs = 0; phold = 0;
      end else begin
        if (phold) begin
          chk("hold_valid", 72'(win_valid), 72'(1));
          chk("hold_data", win_data, pd);
          chk("hold_rowcol", {win_row, win_col, win_last}, {pr, pc, pl});
        end
        if (win_valid && !win_ready) chk("bp_in_ready", 72'(in_ready), 72'(0));
        if (win_valid && (!pv || phs)) pres = cyc;
        if (win_valid && win_ready) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_window actual=row%0d_col%0d required=none", win_row, win_col);
          end else begin
            e = expq.pop_front();
            chk("win_data", win_data, e.data);
            chk("win_row", 72'(win_row), 72'(e.row));
            chk("win_col", 72'(win_col), 72'(e.col));
            chk("win_last", 72'(win_last), 72'(e.last));
            chk("latency", 72'(pres), 72'(e.acc + 1));
            wins_seen++;
            if (win_last) lasts_seen++;
            if (win_row < H && win_col < W) hs_cyc[win_row][win_col] = cyc;
          end
        end
        pv    = win_valid;
        phs   = win_valid && win_ready;
        phold = win_valid && !win_ready;
        pd    = win_data;
        pr    = win_row;
        pc    = win_col;
        pl    = win_last;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_win_valid"}, 72'(win_valid), 72'(0));
    chk({tag, "_in_ready"}, 72'(in_ready), 72'(1));
    chk({tag, "_win_data"}, win_data, 72'(0));
    chk({tag, "_win_rowcol"}, {win_row, win_col, win_last}, 72'(0));
  endtask

  task automatic check_counts(input string tag, input int w0, input int l0, input int nw, input int nl);
    chk({tag, "_windows"}, 72'(wins_seen - w0), 72'(nw));
    chk({tag, "_lasts"}, 72'(lasts_seen - l0), 72'(nl));
  endtask

  initial begin
    int w0, l0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check_reset_state("reset");

    // 1 + 6: full-rate ramp frame
    w0 = wins_seen; l0 = lasts_seen;
    run_frame(0);
    drain();
    check_counts("ramp", w0, l0, 36, 1);
    for (int c = 1; c < 6; c++)
      chk("row4_consecutive", 72'(hs_cyc[4][c]), 72'(hs_cyc[4][0] + c));

    // 2: backpressure on window (2,3)
    wr_mode = 2; bp_cnt = 0;
    w0 = wins_seen; l0 = lasts_seen;
    run_frame(0);
    drain();
    check_counts("bp", w0, l0, 36, 1);
    chk("bp_cycles", 72'(bp_cnt), 72'(5));

    // 3: random input gaps and random consumer ready
    wr_mode = 1; gaps = 1;
    w0 = wins_seen; l0 = lasts_seen;
    run_frame(0);
    drain();
    check_counts("gaps", w0, l0, 36, 1);

    // 4: two back-to-back frames
    wr_mode = 0; gaps = 0;
    w0 = wins_seen; l0 = lasts_seen;
    run_frame(0);
    run_frame(64);
    drain();
    check_counts("b2b", w0, l0, 72, 2);

    // 5: reset mid-frame after 20 pixels
    for (int i = 0; i < 20; i++) drive_pixel(8'(i));
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    mr = 0; mc = 0;
    #2;
    check_reset_state("midreset");
    w0 = wins_seen; l0 = lasts_seen;
    run_frame(0);
    drain();
    check_counts("after_reset", w0, l0, 36, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
